// File: rtl/sat_simd_alu.sv
// Registered saturating SIMD add/sub unit with valid/ready handshaking.
// RED sums every lane of a and b serially, one lane pair per cycle.
module sat_simd_alu #(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             sat
);

    localparam int NUM_LANES = WIDTH / LANE_W;
    localparam int CNT_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_PADD = 2'b10;
    localparam logic [1:0] OP_RED  = 2'b11;

    typedef enum logic {IDLE, RED_ACC} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc, a_q, b_q;
    logic               accept, red_last;
    logic [WIDTH:0]     sum_w;
    logic [LANE_W:0]    lane_sum;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_sat;
    logic [LANE_W-1:0]  lane_a, lane_b;
    logic [WIDTH-1:0]   red_sum;

    function automatic logic [WIDTH-1:0] sext_lane(input logic [LANE_W-1:0] x);
        logic [WIDTH-1:0] r;
        r = {WIDTH{x[LANE_W-1]}};
        r[LANE_W-1:0] = x;
        return r;
    endfunction

    assign in_ready = rst_n & (state == IDLE) & (~out_valid | out_ready);

    // Single-cycle ops: one extra bit catches overflow; clamp when the top two bits disagree.
    always_comb begin
        sum_w    = '0;
        lane_sum = '0;
        alu_res  = '0;
        alu_sat  = 1'b0;
        if (op == OP_SUB)
            sum_w = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        else
            sum_w = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (op == OP_PADD) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_sum = {a[i*LANE_W+LANE_W-1], a[i*LANE_W +: LANE_W]}
                         + {b[i*LANE_W+LANE_W-1], b[i*LANE_W +: LANE_W]};
                if (lane_sum[LANE_W] != lane_sum[LANE_W-1]) begin
                    alu_sat = 1'b1;
                    alu_res[i*LANE_W +: LANE_W] = lane_sum[LANE_W] ?
                        {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
                end else begin
                    alu_res[i*LANE_W +: LANE_W] = lane_sum[LANE_W-1:0];
                end
            end
        end else if (sum_w[WIDTH] != sum_w[WIDTH-1]) begin
            alu_sat = 1'b1;
            alu_res = sum_w[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            alu_res = sum_w[WIDTH-1:0];
        end
    end

    // Accumulator wraps modulo 2^WIDTH, which equals truncating the exact sum.
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (cnt == CNT_W'(i)) begin
                lane_a = a_q[i*LANE_W +: LANE_W];
                lane_b = b_q[i*LANE_W +: LANE_W];
            end
        end
        red_sum = acc + sext_lane(lane_a) + sext_lane(lane_b);
    end

    always_comb begin
        state_nxt = state;
        accept    = in_valid & in_ready;
        red_last  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && op == OP_RED)
                    state_nxt = RED_ACC;
            end
            RED_ACC: begin
                if (cnt == CNT_W'(NUM_LANES - 1)) begin
                    red_last  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result    <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept && op == OP_RED) begin
                a_q <= a;
                b_q <= b;
                cnt <= '0;
                acc <= '0;
            end else if (state == RED_ACC) begin
                acc <= red_sum;
                cnt <= cnt + CNT_W'(1);
            end

            if (accept && op != OP_RED) begin
                result    <= alu_res;
                sat       <= alu_sat;
                out_valid <= 1'b1;
            end else if (red_last) begin
                result    <= red_sum;
                sat       <= 1'b0;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sat_simd_alu.sv
// Bench for sat_simd_alu: directed vector table, backpressure and reset-mid-RED
// sequences, then random operations checked against an arithmetic model.
module tb_sat_simd_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        sat;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sat_simd_alu #(.WIDTH(16), .LANE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .sat(sat)
    );

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        sat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int sx16(input logic [15:0] x);
        int v;
        v = int'(x);
        if (v >= 32768) v -= 65536;
        return v;
    endfunction

    function automatic int sx4(input logic [3:0] x);
        int v;
        v = int'(x);
        if (v >= 8) v -= 16;
        return v;
    endfunction

    // Reference: plain integer arithmetic on the signed values of operands/lanes.
    function automatic void model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] r, output logic s);
        int t;
        r = '0;
        s = 1'b0;
        case (o)
            2'd0, 2'd1: begin
                t = (o == 2'd0) ? sx16(x) + sx16(y) : sx16(x) - sx16(y);
                if (t > 32767)       begin r = 16'h7FFF; s = 1'b1; end
                else if (t < -32768) begin r = 16'h8000; s = 1'b1; end
                else                 r = t[15:0];
            end
            2'd2: begin
                for (int l = 0; l < 4; l++) begin
                    t = sx4(x[4*l +: 4]) + sx4(y[4*l +: 4]);
                    if (t > 7)       begin t = 7;  s = 1'b1; end
                    else if (t < -8) begin t = -8; s = 1'b1; end
                    r[4*l +: 4] = t[3:0];
                end
            end
            default: begin
                t = 0;
                for (int l = 0; l < 4; l++) t += sx4(x[4*l +: 4]) + sx4(y[4*l +: 4]);
                r = t[15:0];
            end
        endcase
    endfunction

    // Issue one request with out_ready=1 and check result, sat, latency and in_ready gap.
    task automatic run_op(input logic [1:0] o, input logic [15:0] va, input logic [15:0] vb,
                          input logic [15:0] er, input logic es, input string tag);
        int w, lat, low;
        @(negedge clk);
        op = o; a = va; b = vb; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        low = 0;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            if (!in_ready) low++;
            lat++;
            @(negedge clk);
        end
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_sat"}, 32'(sat), 32'(es));
        check({tag, "_latency"}, 32'(lat), (o == 2'd3) ? 32'd4 : 32'd0);
        if (o == 2'd3)
            check({tag, "_ready_low_cycles"}, 32'(low), 32'd4);
    endtask

    initial begin
        logic [15:0] er;
        logic        es;
        logic [1:0]  ro;
        logic [15:0] ra, rb;
        int          stray;

        vecs.push_back('{2'd0, 16'h7000, 16'h1000, 16'h7FFF, 1'b1});
        vecs.push_back('{2'd0, 16'h0003, 16'h0004, 16'h0007, 1'b0});
        vecs.push_back('{2'd0, 16'h8000, 16'hFFFF, 16'h8000, 1'b1});
        vecs.push_back('{2'd1, 16'h8000, 16'h0001, 16'h8000, 1'b1});
        vecs.push_back('{2'd1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0});
        vecs.push_back('{2'd1, 16'h0000, 16'h8000, 16'h7FFF, 1'b1});
        vecs.push_back('{2'd1, 16'hFFFF, 16'h8000, 16'h7FFF, 1'b0});
        vecs.push_back('{2'd2, 16'h7F81, 16'h1111, 16'h7092, 1'b1});
        vecs.push_back('{2'd2, 16'h1234, 16'h1111, 16'h2345, 1'b0});
        vecs.push_back('{2'd2, 16'h8000, 16'hF000, 16'h8000, 1'b1});
        vecs.push_back('{2'd3, 16'h7777, 16'h7777, 16'h0038, 1'b0});
        vecs.push_back('{2'd3, 16'h8888, 16'h8888, 16'hFFC0, 1'b0});
        vecs.push_back('{2'd3, 16'h1234, 16'hFFFF, 16'h0006, 1'b0});

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        check("rst_in_ready_low", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1 check("rst_release_in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].sat,
                   $sformatf("vec%0d", i));

        // Backpressure: hold the first result for 5 cycles while a second request waits.
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        op = 2'd0; a = 16'h7000; b = 16'h1000; in_valid = 1'b1;
        check("bp_first_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 op = 2'd0; a = 16'h0003; b = 16'h0004;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold%0d_result", c), 32'(result), 32'h7FFF);
            check($sformatf("bp_hold%0d_sat", c), 32'(sat), 32'd1);
            check($sformatf("bp_hold%0d_in_ready", c), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_valid", 32'(out_valid), 32'd1);
        check("bp_second_result", 32'(result), 32'h0007);
        check("bp_second_sat", 32'(sat), 32'd0);

        // Reset lands on the second accumulate edge of a RED.
        @(negedge clk);
        op = 2'd3; a = 16'h7777; b = 16'h7777; in_valid = 1'b1;
        check("rr_accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("rr_in_ready_in_reset", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("rr_out_valid", 32'(out_valid), 32'd0);
        check("rr_result", 32'(result), 32'd0);
        check("rr_sat", 32'(sat), 32'd0);
        rst_n = 1'b1;
        #1 check("rr_release_in_ready", 32'(in_ready), 32'd1);
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        check("rr_red_discarded", 32'(stray), 32'd0);
        run_op(2'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0, "rr_add");

        for (int n = 0; n < 300; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (n % 8 == 0) rb = 16'h8000;
            model(ro, ra, rb, er, es);
            run_op(ro, ra, rb, er, es, $sformatf("rnd%0d_op%0d", n, ro));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks done", tests);
        $fatal(1, "timeout");
    end

endmodule
